score_controller: RTL
=====================

SCORE_CONTROLLER -- requirements
Module: score_controller

Interface
REQ-001 Parameter HOLD_CYCLES, default 65_000_000, sets the result display hold length in clk cycles (1 s at 65 MHz); legal range is 1 or more.
REQ-002 Parameter ROUNDS, default 5, sets the number of shots per game; the last shot index is ROUNDS-1 (default 4).
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low.
REQ-005 game_state  in  g_state (game_pkg)  current registered game state from the state selector.
REQ-006 game_mode  in  g_mode (game_pkg)  current registered game mode, SOLO or MULTI.
REQ-007 shot_valid  in  1  single-cycle pulse marking that the current shot has been resolved.
REQ-008 shot_saved  in  1  shot outcome, sampled only when shot_valid=1; 1 means the keeper saved, 0 means a goal.
REQ-009 is_scored  out  1  single-cycle pulse marking that round_counter and score are updated for the shot just resolved.
REQ-010 round_counter  out  4  index of the last reported shot, in the range 0..ROUNDS-1.
REQ-011 score  out  3  number of saves in the current game.
REQ-012 last_saved  out  1  outcome of the most recently accepted shot, used by the display.
REQ-013 busy  out  1  high while a result is held; shots are not accepted while busy=1.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, ARMED, HOLD, REPORT, DONE.
REQ-015 IDLE: the block SHALL move to ARMED when game_state is KEEPER or SHOOTER; otherwise it stays in IDLE.
REQ-016 ARMED, shot_valid=1: the block SHALL latch shot_saved into last_saved, load the hold counter with HOLD_CYCLES-1, and go to HOLD.
REQ-017 HOLD: the block SHALL decrement the hold counter once per cycle and go to REPORT in the cycle after the counter reaches 0, so HOLD lasts exactly HOLD_CYCLES cycles.
REQ-018 REPORT lasts one cycle, in which the block SHALL:
- pulse is_scored=1;
- update round_counter to the index of this shot, 0 for the first accepted shot;
- increment score if last_saved=1;
- go to DONE if this was shot index ROUNDS-1, otherwise go to ARMED.
REQ-019 round_counter and score SHALL change only in REPORT (and on clear or reset), and SHALL be stable while is_scored=1.
REQ-020 The registered outputs SHALL satisfy:
- in the is_scored cycle, round_counter already holds the index of the new shot;
- round_counter changes 0 to 1 to ... to ROUNDS-1 and never wraps inside a game.
REQ-021 An internal shot index, 0..ROUNDS-1, SHALL track the next shot; the first REPORT of a game SHALL write 0 to round_counter.
REQ-022 DONE: the block SHALL ignore shot_valid and hold round_counter and score until game_state becomes START.
REQ-023 busy SHALL be 1 exactly in HOLD and REPORT.
REQ-024 shot_valid SHALL be ignored in IDLE, HOLD, REPORT and DONE, with no queuing.
REQ-025 score SHALL saturate at 7 and never wrap.
REQ-026 Clear: whenever game_state==START, from any FSM state, the block SHALL go to IDLE and clear round_counter, score, last_saved, the shot index and the hold counter to 0.
REQ-027 Clear SHALL take priority over a simultaneous shot_valid or REPORT in the same cycle, and is_scored SHALL be 0 in that cycle.
REQ-028 If game_state is WINNER or LOOSER while the FSM is in ARMED, HOLD or REPORT, the block SHALL finish any REPORT in progress and then go to DONE.
REQ-029 If game_mode changes during a game, the block SHALL ignore the change; game_mode does not alter counting.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While rst=0, the block SHALL immediately, without waiting for a clock edge, force:
- FSM = IDLE;
- is_scored=0, round_counter=0, score=0, last_saved=0, busy=0;
- hold counter = 0.
REQ-032 After rst rises, the block SHALL begin operating on the first rising clk edge; a reset in mid-hold SHALL discard the pending shot without pulsing is_scored.

Verification (HOLD_CYCLES=4, ROUNDS=5)
REQ-033 Reset mid-HOLD: drop rst between edges -> all outputs 0 at once; no is_scored pulse follows.
REQ-034 Full game, outcomes save,save,goal,save,goal -> is_scored pulses with (round_counter,score) = (0,1),(1,2),(2,2),(3,3),(4,3) -> FSM in DONE.
REQ-035 Hold timing: shot_valid at edge N -> busy high from N+1; is_scored at N+5 (4 HOLD cycles plus 1 REPORT cycle); busy low at N+6.
REQ-036 Ignored pulses: shot_valid during HOLD, and during DONE -> no change to outputs, no extra is_scored.
REQ-037 Clear conflict: game_state=START in the same cycle as REPORT -> is_scored=0, round_counter=0, score=0 next cycle.
REQ-038 Saturation: ROUNDS=9 override with 9 saves -> score stays at 7; round_counter ends at 8.

Source files
------------

// File: rtl/score_controller.sv
// Penalty-game score keeper: accepts resolved shots, holds each result for display,
// then reports the shot index and running save count.
package game_pkg;
  typedef enum logic [2:0] {START, KEEPER, SHOOTER, WINNER, LOOSER} g_state;
  typedef enum logic {SOLO, MULTI} g_mode;
endpackage

module score_controller
  import game_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 65_000_000,
  parameter int unsigned ROUNDS      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  g_state     game_state,
  input  g_mode      game_mode,
  input  logic       shot_valid,
  input  logic       shot_saved,
  output logic       is_scored,
  output logic [3:0] round_counter,
  output logic [2:0] score,
  output logic       last_saved,
  output logic       busy
);

  localparam int unsigned     HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]      LAST_IDX  = 4'(ROUNDS - 1);
  localparam logic [2:0]      SCORE_MAX = 3'd7;

  typedef enum logic [2:0] {IDLE, ARMED, HOLD, REPORT, DONE} state_t;

  state_t            r_state;
  logic [HOLD_W-1:0] r_hold;
  logic [3:0]        r_shot_idx;
  logic [3:0]        r_round;
  logic [2:0]        r_score;
  logic              r_is_scored;
  logic              r_last_saved;
  logic              r_busy;

  logic w_game_over;
  logic w_unused_mode;

  assign w_game_over   = (game_state == WINNER) || (game_state == LOOSER);
  // Mode has no effect on counting; kept on the port for the display path.
  assign w_unused_mode = (game_mode == MULTI);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_hold       <= '0;
      r_shot_idx   <= '0;
      r_round      <= '0;
      r_score      <= '0;
      r_is_scored  <= 1'b0;
      r_last_saved <= 1'b0;
      r_busy       <= 1'b0;
    end else if (game_state == START) begin
      // Clear wins over any shot or report landing in the same cycle.
      r_state      <= IDLE;
      r_hold       <= '0;
      r_shot_idx   <= '0;
      r_round      <= '0;
      r_score      <= '0;
      r_is_scored  <= 1'b0;
      r_last_saved <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_is_scored <= 1'b0;
      case (r_state)
        IDLE: begin
          if ((game_state == KEEPER) || (game_state == SHOOTER)) begin
            r_state <= ARMED;
          end
        end
        ARMED: begin
          if (w_game_over) begin
            r_state <= DONE;
          end else if (shot_valid) begin
            r_last_saved <= shot_saved;
            r_hold       <= HOLD_LOAD;
            r_busy       <= 1'b1;
            r_state      <= HOLD;
          end
        end
        HOLD: begin
          // An accepted shot always runs through its report, even if the game ends.
          if (r_hold == '0) begin
            r_state     <= REPORT;
            r_is_scored <= 1'b1;
            r_round     <= r_shot_idx;
            if (r_last_saved && (r_score != SCORE_MAX)) begin
              r_score <= r_score + 3'd1;
            end
          end else begin
            r_hold <= r_hold - HOLD_W'(1);
          end
        end
        REPORT: begin
          r_busy <= 1'b0;
          if (w_game_over || (r_shot_idx == LAST_IDX)) begin
            r_state <= DONE;
          end else begin
            r_shot_idx <= r_shot_idx + 4'd1;
            r_state    <= ARMED;
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign is_scored     = r_is_scored;
  assign round_counter = r_round;
  assign score         = r_score;
  assign last_saved    = r_last_saved;
  assign busy          = r_busy;

endmodule
